// File: rtl/fetch_controller_if.sv
// Fetch controller bus bundle.
//   master: fetch_controller side (drives ROM address and the decode handshake)
//   slave : environment side (ROM data, redirect, decode ready)
// Signals:
//   rom_addr/rom_data          combinational instruction ROM read
//   redirect_valid/redirect_pc flush and load a new PC
//   fd_valid/fd_ready          fetch-queue head handshake to decode
//   fd_pc/fd_instr             head entry payload
//   halted                     fetch stopped and queue drained
interface fetch_controller_if #(
  parameter int ADDR_WIDTH  = 12,
  parameter int INSTR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]  rom_addr;
  logic [INSTR_WIDTH-1:0] rom_data;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   fd_valid;
  logic                   fd_ready;
  logic [ADDR_WIDTH-1:0]  fd_pc;
  logic [INSTR_WIDTH-1:0] fd_instr;
  logic                   halted;

  modport master (
    output rom_addr, fd_valid, fd_pc, fd_instr, halted,
    input  rom_data, redirect_valid, redirect_pc, fd_ready
  );

  modport slave (
    input  rom_addr, fd_valid, fd_pc, fd_instr, halted,
    output rom_data, redirect_valid, redirect_pc, fd_ready
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer.
// Owns the PC, addresses the instruction ROM and pushes {pc, instr} pairs into
// a 2-entry queue that feeds decode over a valid/ready handshake. Supports
// backpressure, redirect/flush and halting at the end of the program.
// Ports:
//   clk    clock, all state on posedge
//   reset  asynchronous active-low reset
//   bus    fetch_controller_if.master (ROM, redirect, decode handshake, halted)
module fetch_controller #(
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    PROG_BYTES  = 48
) (
  input logic clk,
  input logic reset,
  fetch_controller_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] PROG_END = ADDR_WIDTH'(PROG_BYTES);

  logic [1:0]             r_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [1:0]             r_cnt;
  logic                   r_head;
  logic [ADDR_WIDTH-1:0]  r_q_pc    [2];
  logic [INSTR_WIDTH-1:0] r_q_instr [2];

  logic                   w_pop;
  logic                   w_push;
  logic                   w_tail;
  logic [ADDR_WIDTH-1:0]  w_pc_next;
  logic [ADDR_WIDTH-1:0]  w_redir_pc;
  logic                   w_nonempty;

  assign w_nonempty = (r_cnt != 2'd0);
  assign w_pc_next  = r_pc + ADDR_WIDTH'(4);
  assign w_redir_pc = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  // Tail slot: head+count mod 2; with count==2 the tail is the head slot,
  // which is only written when the head is popped in the same cycle.
  assign w_tail     = r_head ^ r_cnt[0];

  // Redirect kills the handshake in its own cycle so no stale entry escapes.
  assign bus.fd_valid = w_nonempty && !bus.redirect_valid;
  assign w_pop        = bus.fd_valid && bus.fd_ready;
  assign w_push       = !bus.redirect_valid && (r_state == S_RUN) &&
                        (r_pc < PROG_END) && ((r_cnt != 2'd2) || w_pop);

  assign bus.rom_addr = r_pc;
  assign bus.fd_pc    = w_nonempty ? r_q_pc[r_head]    : '0;
  assign bus.fd_instr = w_nonempty ? r_q_instr[r_head] : '0;
  assign bus.halted   = (r_state == S_HALT) && !w_nonempty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_cnt        <= 2'd0;
      r_head       <= 1'b0;
      r_q_pc[0]    <= '0;
      r_q_pc[1]    <= '0;
      r_q_instr[0] <= '0;
      r_q_instr[1] <= '0;
    end else if (bus.redirect_valid) begin
      r_pc   <= w_redir_pc;
      r_cnt  <= 2'd0;
      r_head <= 1'b0;
      // An out-of-range target from RUN halts on the next cycle via the pc check.
      if (r_state == S_HALT)
        r_state <= (w_redir_pc < PROG_END) ? S_RUN : S_HALT;
      else
        r_state <= S_RUN;
    end else begin
      if (w_push) begin
        r_q_pc[w_tail]    <= r_pc;
        r_q_instr[w_tail] <= bus.rom_data;
        r_pc              <= w_pc_next;
      end
      if (w_pop)
        r_head <= ~r_head;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 2'd1;
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - 2'd1;

      case (r_state)
        S_IDLE: r_state <= S_RUN;
        S_RUN:  if ((w_push && (w_pc_next >= PROG_END)) || (r_pc >= PROG_END))
                  r_state <= S_HALT;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a scoreboard queue of expected
// {pc, instr} pairs is filled when a fetch stream is started and drained by a
// negedge monitor on every accepted decode transfer.
module tb_fetch_controller;
  localparam int AW = 12;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [AW-1:0] last_pc = '0;
  logic [AW+IW-1:0] exp_q [$];

  always #5 clk = ~clk;

  fetch_controller_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  fetch_controller #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC('0),
                     .PROG_BYTES(48))
    dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic logic [IW-1:0] rom_word(input logic [AW-1:0] a);
    return (a == '0) ? 32'h0050_0093 : (32'h1000_0000 | {20'd0, a});
  endfunction

  always_comb bus.rom_data = rom_word(bus.rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_stream(input logic [AW-1:0] from, input logic [AW-1:0] upto);
    for (logic [AW-1:0] a = from; a <= upto; a += 4)
      exp_q.push_back({a, rom_word(a)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard drain and occupancy bound.
  always @(negedge clk) begin
    if (reset) begin
      check("count_le_2", {31'd0, (dut.r_cnt <= 2'd2)}, 32'd1);
      if (bus.fd_valid && bus.fd_ready) begin
        logic [AW+IW-1:0] e;
        if (exp_q.size() == 0) begin
          check("unexpected_xfer_pc", {20'd0, bus.fd_pc}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("xfer_pc", {20'd0, bus.fd_pc}, {20'd0, e[AW+IW-1:IW]});
          check("xfer_instr", bus.fd_instr, e[IW-1:0]);
        end
        last_pc = bus.fd_pc;
      end
    end
  end

  task automatic run_to_halt();
    for (int i = 0; i < 40 && !bus.halted; i++) step();
    check("halted", {31'd0, bus.halted}, 32'd1);
    check("halt_rom_addr", {20'd0, bus.rom_addr}, 32'h030);
    check("last_pc", {20'd0, last_pc}, 32'h02C);
    check("sb_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    bus.fd_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.fd_valid}, 32'd0);
    check("rst_pc", {20'd0, bus.fd_pc}, 32'd0);
    check("rst_instr", bus.fd_instr, 32'd0);
    check("rst_halted", {31'd0, bus.halted}, 32'd0);
    check("rst_rom_addr", {20'd0, bus.rom_addr}, 32'd0);

    // 1: release reset, first valid after 2nd edge
    push_stream(12'h000, 12'h02C);
    reset = 1'b1;
    step();
    check("s1_valid_e1", {31'd0, bus.fd_valid}, 32'd0);
    step();
    check("s1_valid_e2", {31'd0, bus.fd_valid}, 32'd1);
    check("s1_pc", {20'd0, bus.fd_pc}, 32'h000);
    check("s1_instr", bus.fd_instr, 32'h0050_0093);

    // 2: backpressure for 5 cycles, then release
    bus.fd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("s2_hold_pc", {20'd0, bus.fd_pc}, 32'h000);
    end
    check("s2_rom_addr", {20'd0, bus.rom_addr}, 32'h008);
    check("s2_full", {30'd0, dut.r_cnt}, 32'd2);
    bus.fd_ready = 1'b1;
    step();
    check("s2_rel_pc1", {20'd0, bus.fd_pc}, 32'h004);
    step();
    check("s2_rel_pc2", {20'd0, bus.fd_pc}, 32'h008);

    // 3: redirect to unaligned 0x01A mid-stream
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 12'h01A;
    exp_q.delete();
    push_stream(12'h018, 12'h02C);
    #1;
    check("s3_valid_kill", {31'd0, bus.fd_valid}, 32'd0);
    step();
    bus.redirect_valid = 1'b0;
    check("s3_rom_addr", {20'd0, bus.rom_addr}, 32'h018);
    check("s3_flushed", {31'd0, bus.fd_valid}, 32'd0);
    step();
    check("s3_valid", {31'd0, bus.fd_valid}, 32'd1);
    check("s3_pc", {20'd0, bus.fd_pc}, 32'h018);

    // 4: run to end of program
    run_to_halt();

    // 5: redirect out of halt
    push_stream(12'h010, 12'h02C);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 12'h010;
    step();
    bus.redirect_valid = 1'b0;
    check("s5_halted", {31'd0, bus.halted}, 32'd0);
    check("s5_rom_addr", {20'd0, bus.rom_addr}, 32'h010);
    step();
    check("s5_pc1", {20'd0, bus.fd_pc}, 32'h010);
    step();
    check("s5_pc2", {20'd0, bus.fd_pc}, 32'h014);

    // 6: fill the queue, then asynchronous reset mid-cycle
    bus.fd_ready = 1'b0;
    repeat (3) step();
    check("s6_full", {30'd0, dut.r_cnt}, 32'd2);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("s6_rst_valid", {31'd0, bus.fd_valid}, 32'd0);
    check("s6_rst_rom_addr", {20'd0, bus.rom_addr}, 32'd0);
    check("s6_rst_halted", {31'd0, bus.halted}, 32'd0);
    step();
    push_stream(12'h000, 12'h02C);
    reset = 1'b1;
    bus.fd_ready = 1'b1;
    step();
    check("s6_valid_e1", {31'd0, bus.fd_valid}, 32'd0);
    step();
    check("s6_valid_e2", {31'd0, bus.fd_valid}, 32'd1);
    check("s6_pc", {20'd0, bus.fd_pc}, 32'h000);
    check("s6_instr", bus.fd_instr, 32'h0050_0093);
    run_to_halt();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
